regfile_wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the 16x32b 4-read/2-write register file.
- Collects results from three execution sources (ALU, MUL, LOAD) over valid/ready handshakes and buffers each in a 2-entry FIFO.
- Each cycle, grants up to two buffered results to the register file's two write ports.
- Never issues two writes to the same address in one cycle, so the register file's write-collision rule is never exercised.

---
 rtl/regfile_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of the 16x32b 4-read/2-write register file.
// Each of the three result sources (ALU, MUL, LOAD) feeds its own 2-entry FIFO.
// Every cycle up to two FIFO heads are granted to the two registered write ports.
// Grants rotate round-robin, and two writes to the same address are never paired.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NSRC   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSRC-1:0]          src_valid,
  output logic [NSRC-1:0]          src_ready,
  input  logic [NSRC*ADDR_W-1:0]   src_addr,
  input  logic [NSRC*DATA_W-1:0]   src_data,
  output logic [ADDR_W-1:0]        wrport1_ctrl_add,
  output logic [DATA_W-1:0]        wrport1_data_in,
  output logic                     wrport1_wren,
  output logic [ADDR_W-1:0]        wrport2_ctrl_add,
  output logic [DATA_W-1:0]        wrport2_data_in,
  output logic                     wrport2_wren,
  output logic                     busy
);

  // Per-source FIFO storage; the pointers are one bit because the depth is 2.
  logic [ADDR_W-1:0] fifo_addr [NSRC][2];
  logic [DATA_W-1:0] fifo_data [NSRC][2];
  logic              rd_ptr    [NSRC];
  logic              wr_ptr    [NSRC];
  logic [1:0]        count     [NSRC];
  logic [ADDR_W-1:0] head_addr [NSRC];
  logic [DATA_W-1:0] head_data [NSRC];

  logic [NSRC-1:0] push;
  logic [NSRC-1:0] pop;
  logic [1:0]      rr;
  logic [1:0]      scan [NSRC];
  logic            a_vld;
  logic            b_vld;
  logic [1:0]      a_idx;
  logic [1:0]      b_idx;

  // Successor index modulo 3.
  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Ready depends only on occupancy, so a full FIFO stays not-ready even while it pops.
  always_comb begin
    src_ready = '0;
    push      = '0;
    for (int s = 0; s < NSRC; s++) begin
      src_ready[s] = !rst && (count[s] < 2'd2);
      push[s]      = src_valid[s] && src_ready[s];
      head_addr[s] = fifo_addr[s][rd_ptr[s]];
      head_data[s] = fifo_data[s][rd_ptr[s]];
    end
  end

  // Scan heads from rr; A is the first non-empty head, B the next one with a different address.
  always_comb begin
    a_vld = 1'b0;
    b_vld = 1'b0;
    a_idx = 2'd0;
    b_idx = 2'd0;
    pop   = '0;
    scan[0] = rr;
    for (int k = 1; k < NSRC; k++) begin
      scan[k] = nxt(scan[k-1]);
    end
    for (int k = 0; k < NSRC; k++) begin
      if (count[scan[k]] != 2'd0) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = scan[k];
        end else if (!b_vld && (head_addr[scan[k]] != head_addr[a_idx])) begin
          b_vld = 1'b1;
          b_idx = scan[k];
        end
      end
    end
    if (a_vld) pop[a_idx] = 1'b1;
    if (b_vld) pop[b_idx] = 1'b1;
  end

  // FIFO writes, pointer advance and occupancy tracking; reset discards buffered entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSRC; s++) begin
        count[s]  <= 2'd0;
        rd_ptr[s] <= 1'b0;
        wr_ptr[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        if (push[s]) begin
          fifo_addr[s][wr_ptr[s]] <= src_addr[s*ADDR_W +: ADDR_W];
          fifo_data[s][wr_ptr[s]] <= src_data[s*DATA_W +: DATA_W];
          wr_ptr[s]               <= ~wr_ptr[s];
        end
        if (pop[s]) begin
          rd_ptr[s] <= ~rd_ptr[s];
        end
        if (push[s] && !pop[s]) begin
          count[s] <= count[s] + 2'd1;
        end else if (!push[s] && pop[s]) begin
          count[s] <= count[s] - 2'd1;
        end
      end
    end
  end

  // Write-port registers load at the pop edge; address/data hold when a port is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr               <= 2'd0;
      wrport1_wren     <= 1'b0;
      wrport1_ctrl_add <= '0;
      wrport1_data_in  <= '0;
      wrport2_wren     <= 1'b0;
      wrport2_ctrl_add <= '0;
      wrport2_data_in  <= '0;
    end else begin
      wrport1_wren <= a_vld;
      wrport2_wren <= b_vld;
      if (a_vld) begin
        rr               <= nxt(a_idx);
        wrport1_ctrl_add <= head_addr[a_idx];
        wrport1_data_in  <= head_data[a_idx];
      end
      if (b_vld) begin
        wrport2_ctrl_add <= head_addr[b_idx];
        wrport2_data_in  <= head_data[b_idx];
      end
    end
  end

  // Busy while anything is buffered or a write is being presented.
  always_comb begin
    busy = wrport1_wren || wrport2_wren;
    for (int s = 0; s < NSRC; s++) begin
      busy = busy || (count[s] != 2'd0);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a random phase,
// all checked cycle by cycle against a queue-level reference model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [11:0] src_addr;
  logic [95:0] src_data;
  logic [3:0]  wrport1_ctrl_add;
  logic [31:0] wrport1_data_in;
  logic        wrport1_wren;
  logic [3:0]  wrport2_ctrl_add;
  logic [31:0] wrport2_data_in;
  logic        wrport2_wren;
  logic        busy;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(4), .NSRC(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .src_valid        (src_valid),
    .src_ready        (src_ready),
    .src_addr         (src_addr),
    .src_data         (src_data),
    .wrport1_ctrl_add (wrport1_ctrl_add),
    .wrport1_data_in  (wrport1_data_in),
    .wrport1_wren     (wrport1_wren),
    .wrport2_ctrl_add (wrport2_ctrl_add),
    .wrport2_data_in  (wrport2_data_in),
    .wrport2_wren     (wrport2_wren),
    .busy             (busy)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
  } ent_t;

  // Reference model: each source holds an ordered list of up to two pending results.
  ent_t        fm [3][2];
  int          sz [3];
  int          rr_m;
  logic        exp_w1, exp_w2;
  logic [3:0]  exp_a1, exp_a2;
  logic [31:0] exp_d1, exp_d2;

  logic [31:0] obs_rf [16];
  int          checks;
  int          errors;
  int          cyc;
  logic [2:0]  last_acc;
  logic        count_writes;
  int          writes_seen;
  logic        saw_mul_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check ready, advance model, check outputs.
  task automatic step(input logic r, input logic [2:0] v, input logic [11:0] a, input logic [95:0] d);
    logic [2:0] exp_rdy;
    int ga, gb, s;
    rst = r;
    src_valid = v;
    src_addr = a;
    src_data = d;
    #1;
    for (int i = 0; i < 3; i++) exp_rdy[i] = !r && (sz[i] < 2);
    check("src_ready", 32'(src_ready), 32'(exp_rdy));
    if (!r && !src_ready[1]) saw_mul_stall = 1'b1;
    @(posedge clk);
    cyc++;
    last_acc = v & exp_rdy;
    if (r) begin
      for (int i = 0; i < 3; i++) sz[i] = 0;
      rr_m = 0;
      exp_w1 = 0; exp_w2 = 0;
      exp_a1 = 0; exp_a2 = 0;
      exp_d1 = 0; exp_d2 = 0;
    end else begin
      ga = -1;
      gb = -1;
      for (int k = 0; k < 3; k++) begin
        s = (rr_m + k) % 3;
        if (sz[s] > 0) begin
          if (ga < 0) ga = s;
          else if (gb < 0 && fm[s][0].a != fm[ga][0].a) gb = s;
        end
      end
      exp_w1 = (ga >= 0);
      exp_w2 = (gb >= 0);
      if (ga >= 0) begin
        exp_a1 = fm[ga][0].a;
        exp_d1 = fm[ga][0].d;
        rr_m = (ga + 1) % 3;
      end
      if (gb >= 0) begin
        exp_a2 = fm[gb][0].a;
        exp_d2 = fm[gb][0].d;
      end
      for (int i = 0; i < 3; i++) begin
        if (i == ga || i == gb) begin
          fm[i][0] = fm[i][1];
          sz[i]--;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (last_acc[i]) begin
          fm[i][sz[i]] = '{a: a[i*4 +: 4], d: d[i*32 +: 32]};
          sz[i]++;
        end
      end
    end
    #1;
    check("wren1", 32'(wrport1_wren), 32'(exp_w1));
    check("addr1", 32'(wrport1_ctrl_add), 32'(exp_a1));
    check("data1", wrport1_data_in, exp_d1);
    check("wren2", 32'(wrport2_wren), 32'(exp_w2));
    check("addr2", 32'(wrport2_ctrl_add), 32'(exp_a2));
    check("data2", wrport2_data_in, exp_d2);
    check("busy", 32'(busy), 32'(exp_w1 || exp_w2 || sz[0] > 0 || sz[1] > 0 || sz[2] > 0));
    check("collision", 32'(wrport1_wren && wrport2_wren && (wrport1_ctrl_add == wrport2_ctrl_add)), 32'd0);
    if (wrport1_wren) obs_rf[wrport1_ctrl_add] = wrport1_data_in;
    if (wrport2_wren) obs_rf[wrport2_ctrl_add] = wrport2_data_in;
    if (count_writes) writes_seen += int'(wrport1_wren) + int'(wrport2_wren);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 12'h0, 96'h0);
  endtask

  initial begin
    logic [11:0] ra;
    logic [95:0] rd;
    logic [2:0]  rv;
    logic [3:0]  mul_addrs [4];
    int          mul_i;
    checks = 0; errors = 0; cyc = 0;
    rr_m = 0;
    for (int i = 0; i < 3; i++) sz[i] = 0;
    exp_w1 = 0; exp_w2 = 0; exp_a1 = 0; exp_a2 = 0; exp_d1 = 0; exp_d2 = 0;
    count_writes = 0; writes_seen = 0; saw_mul_stall = 0;
    rst = 1'b1; src_valid = '0; src_addr = '0; src_data = '0;
    @(negedge clk);

    // Reset then a single ALU write.
    step(1'b1, 3'b111, 12'hFFF, {3{32'hFFFF_FFFF}});
    step(1'b0, 3'b001, {4'd0, 4'd0, 4'd5}, {64'h0, 32'hDEAD_BEEF});
    step(1'b0, 3'b000, 12'h0, 96'h0);
    check("t1_wren1", 32'(wrport1_wren), 32'd1);
    check("t1_addr1", 32'(wrport1_ctrl_add), 32'd5);
    check("t1_data1", wrport1_data_in, 32'hDEAD_BEEF);
    check("t1_wren2", 32'(wrport2_wren), 32'd0);
    step(1'b0, 3'b000, 12'h0, 96'h0);
    check("t1_busy", 32'(busy), 32'd0);

    // Dual issue from ALU and MUL.
    step(1'b1, 3'b000, 12'h0, 96'h0);
    step(1'b0, 3'b011, {4'd0, 4'd2, 4'd1}, {32'h0, 32'h22, 32'h11});
    step(1'b0, 3'b000, 12'h0, 96'h0);
    check("t2_pair", {wrport1_wren, wrport1_ctrl_add, wrport1_data_in[7:0], wrport2_wren, wrport2_ctrl_add, wrport2_data_in[7:0]},
          {1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h22});
    idle(1);

    // Same-address collision between ALU and LOAD.
    step(1'b1, 3'b000, 12'h0, 96'h0);
    step(1'b0, 3'b101, {4'd7, 4'd0, 4'd7}, {32'hB, 32'h0, 32'hA});
    step(1'b0, 3'b000, 12'h0, 96'h0);
    check("t3_first", {wrport1_wren, wrport1_ctrl_add, wrport1_data_in[7:0], wrport2_wren}, {1'b1, 4'd7, 8'hA, 1'b0});
    step(1'b0, 3'b000, 12'h0, 96'h0);
    check("t3_second", {wrport1_wren, wrport1_ctrl_add, wrport1_data_in[7:0]}, {1'b1, 4'd7, 8'hB});
    check("t3_final", obs_rf[7], 32'hB);

    // Three-way: MUL collides with ALU and is skipped for LOAD.
    step(1'b1, 3'b000, 12'h0, 96'h0);
    step(1'b0, 3'b111, {4'd9, 4'd3, 4'd3}, {32'h99, 32'h33, 32'h31});
    step(1'b0, 3'b000, 12'h0, 96'h0);
    check("t4_first", {wrport1_ctrl_add, wrport1_data_in[7:0], wrport2_wren, wrport2_ctrl_add, wrport2_data_in[7:0]},
          {4'd3, 8'h31, 1'b1, 4'd9, 8'h99});
    step(1'b0, 3'b000, 12'h0, 96'h0);
    check("t4_second", {wrport1_wren, wrport1_ctrl_add, wrport1_data_in[7:0]}, {1'b1, 4'd3, 8'h33});
    idle(1);

    // Backpressure: MUL streams four distinct addresses while ALU and LOAD saturate.
    step(1'b1, 3'b000, 12'h0, 96'h0);
    mul_addrs[0] = 4'd0; mul_addrs[1] = 4'd1; mul_addrs[2] = 4'd2; mul_addrs[3] = 4'd3;
    mul_i = 0;
    saw_mul_stall = 0;
    for (int c = 0; c < 16; c++) begin
      rv = {1'b1, (mul_i < 4), 1'b1};
      ra = {4'($urandom_range(12, 15)), mul_addrs[mul_i % 4], 4'($urandom_range(8, 11))};
      rd = {$urandom, 32'h100 + 32'(mul_i), $urandom};
      step(1'b0, rv, ra, rd);
      if (last_acc[1]) mul_i++;
    end
    idle(6);
    check("t5_mul_stall", 32'(saw_mul_stall), 32'd1);
    check("t5_mul_sent", 32'(mul_i), 32'd4);

    // Reset mid-flight discards all buffered results.
    step(1'b0, 3'b111, {4'd4, 4'd5, 4'd6}, {32'h44, 32'h55, 32'h66});
    step(1'b0, 3'b111, {4'd7, 4'd8, 4'd9}, {32'h77, 32'h88, 32'h99});
    step(1'b1, 3'b111, {4'd1, 4'd2, 4'd3}, {32'h1, 32'h2, 32'h3});
    check("t6_idle", {wrport1_wren, wrport2_wren, busy}, 32'd0);
    count_writes = 1;
    writes_seen = 0;
    idle(5);
    count_writes = 0;
    check("t6_no_writes", 32'(writes_seen), 32'd0);

    // Random traffic with narrow address range to provoke collisions.
    for (int c = 0; c < 400; c++) begin
      rv = 3'($urandom_range(0, 7));
      for (int s = 0; s < 3; s++) begin
        ra[s*4 +: 4] = 4'($urandom_range(0, 4));
        rd[s*32 +: 32] = $urandom;
      end
      step(($urandom_range(0, 59) == 0), rv, ra, rd);
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
